// File: rtl/sort_unload.sv
// Parallel-to-serial unload stage behind the final bitonic sort step.
// Optional build macro SORT_UNLOAD_REV_EN adds a per-vector descending-emission input 'rev'.
module sort_unload #(
  parameter int unsigned width = 8,
  parameter int unsigned index = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SORT_UNLOAD_REV_EN
  input  logic             rev,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data [0:index-1],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [$clog2(index)-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(index);
  localparam logic [CW-1:0] LAST_CNT = CW'(index - 1);

  if ((index < 2) || ((index & (index - 1)) != 0)) begin : g_bad_index
    $error("sort_unload: index must be a power of 2 and at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [width-1:0] data_q [0:index-1];
  logic [width-1:0] data_d [0:index-1];
`ifdef SORT_UNLOAD_REV_EN
  logic             rev_q,   rev_d;
`endif

  logic [CW-1:0] pos;
  logic          last_beat;
  logic          capture;

  // cnt counts beats; pos maps the beat onto a buffer position.
  always_comb begin
`ifdef SORT_UNLOAD_REV_EN
    pos = rev_q ? (LAST_CNT - cnt_q) : cnt_q;
`else
    pos = cnt_q;
`endif
    last_beat = (state_q == SEND) && (cnt_q == LAST_CNT);
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    busy      = 1'b0;

    if (state_q == SEND) begin
      out_valid = 1'b1;
      out_data  = data_q[pos];
      out_idx   = pos;
      out_last  = last_beat;
      busy      = 1'b1;
    end

    // Refill is allowed on the handshake of the final beat, giving zero-bubble back-to-back.
    if (rst) begin
      in_ready = (state_q == IDLE) || (last_beat && out_ready);
    end

    capture = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef SORT_UNLOAD_REV_EN
    rev_d   = rev_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = capture ? SEND : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (capture) begin
      for (int unsigned i = 0; i < index; i++) begin
        data_d[i] = in_data[i];
      end
`ifdef SORT_UNLOAD_REV_EN
      rev_d = rev;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < index; i++) begin
        data_q[i] <= '0;
      end
`ifdef SORT_UNLOAD_REV_EN
      rev_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int unsigned i = 0; i < index; i++) begin
        data_q[i] <= data_d[i];
      end
`ifdef SORT_UNLOAD_REV_EN
      rev_q   <= rev_d;
`endif
    end
  end

endmodule

// File: tb/tb_sort_unload.sv
// Scoreboard bench for sort_unload: expected beats are queued at capture and checked on emission.
module tb_sort_unload;

  localparam int unsigned W = 8;
  localparam int unsigned N = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data [0:N-1];
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_idx;
  logic         out_last;
  logic         busy;
`ifdef SORT_UNLOAD_REV_EN
  logic         rev;
`endif

  sort_unload #(.width(W), .index(N)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SORT_UNLOAD_REV_EN
    .rev       (rev),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic [2:0]   i;
    logic         l;
  } exp_t;

  exp_t q[$];
  int   vectors;
  int   miscompares;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: checks outputs against the scoreboard on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data",  {24'd0, out_data},  32'd0);
      chk("rst_out_idx",   {29'd0, out_idx},   32'd0);
      chk("rst_out_last",  {31'd0, out_last},  32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("busy",      {31'd0, busy},      {31'd0, q.size() != 0});
      chk("in_ready",  {31'd0, in_ready},
          {31'd0, (q.size() == 0) || (out_ready && q[0].l)});
      if (out_valid && q.size() != 0) begin
        chk("out_data", {24'd0, out_data}, {24'd0, q[0].d});
        chk("out_idx",  {29'd0, out_idx},  {29'd0, q[0].i});
        chk("out_last", {31'd0, out_last}, {31'd0, q[0].l});
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < N; k++) begin
          exp_t e;
          int   p;
          p = k;
`ifdef SORT_UNLOAD_REV_EN
          if (rev) p = N - 1 - k;
`endif
          e.d = in_data[p];
          e.i = 3'(p);
          e.l = (k == N - 1);
          q.push_back(e);
        end
      end
    end
  end

  task automatic scramble();
    for (int k = 0; k < N; k++) in_data[k] = W'($urandom);
  endtask

  task automatic capture(input logic [W-1:0] v [0:N-1]);
    int budget;
    budget = 40;
    while (!in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) chk("timeout_capture", 32'd1, 32'd0);
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) in_data[k] = v[k];
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_idx(input int idx);
    int budget;
    budget = 40;
    do begin
      @(posedge clk); #1;
      budget--;
    end while (!(out_valid && out_idx == 3'(idx)) && budget > 0);
    if (budget == 0) chk("timeout_idx", 32'd1, 32'd0);
  endtask

  task automatic wait_last();
    int budget;
    budget = 40;
    while (!(out_valid && out_last) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) chk("timeout_last", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int budget;
    budget = 60;
    while (out_valid && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) chk("timeout_drain", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  logic [W-1:0] va [0:N-1];
  logic [W-1:0] vb [0:N-1];
  logic [W-1:0] vc [0:N-1];

  initial begin
    vectors     = 0;
    miscompares = 0;
    va = '{8'd3, 8'd7, 8'd9, 8'd12, 8'd20, 8'd33, 8'd41, 8'd60};
    vb = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    for (int k = 0; k < N; k++) vc[k] = 8'(16 * k + 5);

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef SORT_UNLOAD_REV_EN
    rev       = 1'b0;
`endif
    scramble();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_busy",     {31'd0, busy},     32'd0);

    // Basic drain with a 4-cycle stall on idx 2; garbage offered mid-stream must be refused.
    capture(va);
    wait_idx(2);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (4) begin
      #1 chk("stall_data", {24'd0, out_data}, 32'd9);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Back-to-back second vector on the last beat.
    wait_last();
    chk("b2b_last_data", {24'd0, out_data}, 32'd60);
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) in_data[k] = vb[k];
    #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    chk("b2b_first_data", {24'd0, out_data}, 32'd1);
    drain();

    // Reset asserted mid-stream.
    capture(vc);
    wait_idx(4);
    #2 rst = 1'b0;
    #1 chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    capture(va);
    chk("restart_idx", {29'd0, out_idx}, 32'd0);
    drain();

`ifdef SORT_UNLOAD_REV_EN
    rev = 1'b1;
    capture(va);
    rev = 1'b0;
    chk("rev_first", {24'd0, out_data}, 32'd60);
    repeat (3) begin
      @(posedge clk); #1 rev = ~rev;
    end
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
